// File: rtl/fifo_unpacker.sv
// Read-side width converter: splits each full-width FIFO word into p_num_split
// narrow slices, MSB slice first. Optional resp_last port under FIFO_UNPACKER_LAST_EN.
module fifo_unpacker #(
   parameter int p_bit_width = 3,
   parameter int p_num_split = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [p_bit_width*p_num_split-1:0]   req_msg,
   input  logic                                 req_val,
   output logic                                 req_rdy,
   output logic [p_bit_width-1:0]               resp_msg,
   output logic                                 resp_val,
   input  logic                                 resp_rdy
`ifdef FIFO_UNPACKER_LAST_EN
  ,output logic                                 resp_last
`endif
);

   localparam int p_full_bit_width = p_bit_width * p_num_split;
   localparam int CW = (p_num_split > 1) ? $clog2(p_num_split) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(p_num_split - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [p_full_bit_width-1:0] data_q, data_d;
   logic [p_full_bit_width-1:0] shifted;
   logic                        last_beat;
   logic                        resp_fire;
   logic                        req_fire;

   assign last_beat = (cnt_q == LAST_CNT);
   assign resp_val  = (state_q == BUSY);
   assign resp_fire = resp_val & resp_rdy;
   // Ready passes through from resp_rdy on the final beat so words stream without bubbles.
   assign req_rdy   = !reset & ((state_q == IDLE) | (resp_fire & last_beat));
   assign req_fire  = req_val & req_rdy;

   assign shifted  = data_q << (int'(cnt_q) * p_bit_width);
   assign resp_msg = shifted[p_full_bit_width-1 -: p_bit_width];

`ifdef FIFO_UNPACKER_LAST_EN
   assign resp_last = resp_val & last_beat;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      if (req_fire) begin
         data_d  = req_msg;
         cnt_d   = '0;
         state_d = BUSY;
      end else if (resp_fire) begin
         if (last_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

endmodule
